sigmoid_vec: RTL

- Multi-channel activation pipeline for the post-processing head.
- Applies a piecewise-quadratic sigmoid or tanh approximation to NUM_CH fixed-point lanes per beat.
- Lanes share a valid/ready handshake and can stall under downstream backpressure.
- Sits between the final conv accumulator output and the lane-decision logic. Replaces the fixed single-lane, no-backpressure sigmoid unit.

---
 rtl/sigmoid_vec.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/sigmoid_vec.sv
// sigmoid_vec
//    Multi-lane piecewise-quadratic sigmoid / tanh activation pipeline.
//    Every beat carries NUM_CH signed fixed-point samples plus a mode bit
//    (0 = sigmoid, 1 = tanh).  Three register stages, bubble-collapsing
//    valid/ready handshake, one beat per cycle when unstalled.
//
// Ports
//    clk      rising-edge clock
//    rst      synchronous active-high reset
//    i_data   packed input samples, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//    i_mode   0 = sigmoid, 1 = tanh, travels with its beat
//    i_valid  input beat valid
//    o_ready  block can accept a beat this cycle
//    o_data   packed results, same layout as i_data
//    o_valid  output beat valid
//    i_ready  downstream accepts the output beat
//
// Optional build macro
//    SIGMOID_VEC_ROUND_EN  round-half-up at the final truncation instead of
//                          floor, saturating to +1.0 (and -1.0 in tanh mode).

module sigmoid_vec #(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 10,
   parameter int NUM_CH     = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
   input  logic                         i_mode,
   input  logic                         i_valid,
   output logic                         o_ready,
   output logic [NUM_CH*DATA_WIDTH-1:0] o_data,
   output logic                         o_valid,
   input  logic                         i_ready
);

   if (DATA_WIDTH - FRAC_BITS < 4) begin : g_param_check
      $error("sigmoid_vec: DATA_WIDTH-FRAC_BITS must be at least 4");
   end

   // WW: sample sign-extended by two bits so that 2x and |2x| never overflow.
   // MW: offset |1 -/+ x/4| with FRAC_BITS+2 fractional bits, range [0, 1].
   // SW: square of the offset plus one headroom bit for the constant 2^(2F+5).
   // TW: signed working width for the tanh rescale and rounding.
   localparam int WW    = DATA_WIDTH + 2;
   localparam int MW    = FRAC_BITS + 3;
   localparam int SW    = 2*FRAC_BITS + 6;
   localparam int TW    = 2*FRAC_BITS + 8;
   localparam int SHIFT = FRAC_BITS + 5;

   localparam logic [WW-1:0]        LIMIT   = WW'(1) << (FRAC_BITS + 2);
   localparam logic [SW-1:0]        ONE_N   = SW'(1) << (2*FRAC_BITS + 5);
   localparam logic signed [TW-1:0] ONE_N_T = signed'(TW'(1) << (2*FRAC_BITS + 5));
   localparam logic signed [TW-1:0] ONE_OUT = signed'(TW'(1) << FRAC_BITS);
`ifdef SIGMOID_VEC_ROUND_EN
   localparam logic signed [TW-1:0] HALF_LSB = signed'(TW'(1) << (FRAC_BITS + 4));
`endif

   // In units of 2^-(F+2) the offset is 2^(F+2) - |s| for both signs of x.
   // Samples beyond +/-4 get a zero offset, which makes the later stages
   // produce exactly 0 (negative side) or 1 (positive side).
   function automatic logic [MW:0] stage1_lane(input logic [DATA_WIDTH-1:0] samp,
                                               input logic                  tanh_mode);
      logic [WW-1:0] wide;
      logic [WW-1:0] mag;
      wide = {{2{samp[DATA_WIDTH-1]}}, samp};
      if (tanh_mode) wide = {wide[WW-2:0], 1'b0};
      mag = wide[WW-1] ? -wide : wide;
      if (mag > LIMIT) return {wide[WW-1], {MW{1'b0}}};
      return {wide[WW-1], MW'(LIMIT - mag)};
   endfunction

   // The square carries 2F+4 fractional bits; halving adds one more, so the
   // sigmoid value scaled by 2^(2F+5) is an exact integer n.  tanh is then
   // 2n - 2^(2F+5) on the same scale, and one arithmetic shift is the floor.
   function automatic logic [DATA_WIDTH-1:0] stage3_lane(input logic [SW-1:0] sq,
                                                         input logic          neg,
                                                         input logic          tanh_mode);
      logic [SW-1:0]        n;
      logic signed [TW-1:0] t;
      logic signed [TW-1:0] q;
      n = neg ? sq : ONE_N - sq;
      t = signed'(TW'(n));
      if (tanh_mode) t = (t <<< 1) - ONE_N_T;
`ifdef SIGMOID_VEC_ROUND_EN
      t = t + HALF_LSB;
`endif
      q = t >>> SHIFT;
      if (q > ONE_OUT)       q = ONE_OUT;
      else if (q < -ONE_OUT) q = -ONE_OUT;
      return DATA_WIDTH'(q);
   endfunction

   logic                       s1_valid_q, s1_valid_d;
   logic                       s1_mode_q,  s1_mode_d;
   logic [NUM_CH-1:0]          s1_neg_q,   s1_neg_d;
   logic [NUM_CH-1:0][MW-1:0]  s1_m_q,     s1_m_d;

   logic                       s2_valid_q, s2_valid_d;
   logic                       s2_mode_q,  s2_mode_d;
   logic [NUM_CH-1:0]          s2_neg_q,   s2_neg_d;
   logic [NUM_CH-1:0][SW-1:0]  s2_sq_q,    s2_sq_d;

   logic                         s3_valid_q, s3_valid_d;
   logic [NUM_CH*DATA_WIDTH-1:0] s3_data_q,  s3_data_d;

   logic adv1, adv2, adv3;

   // A stage advances when it is empty or the stage after it advances;
   // stage 3 advances when empty or being drained downstream.
   assign adv3    = ~s3_valid_q | i_ready;
   assign adv2    = ~s2_valid_q | adv3;
   assign adv1    = ~s1_valid_q | adv2;
   assign o_ready = ~rst & adv1;
   assign o_valid = s3_valid_q;
   assign o_data  = s3_data_q;

   // Valids move whenever their stage advances; data registers only load
   // when a real beat enters, so idle cycles leave them untouched.
   always_comb begin
      s1_valid_d = adv1 ? i_valid : s1_valid_q;
      s1_mode_d  = s1_mode_q;
      s1_neg_d   = s1_neg_q;
      s1_m_d     = s1_m_q;
      s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;
      s2_mode_d  = s2_mode_q;
      s2_neg_d   = s2_neg_q;
      s2_sq_d    = s2_sq_q;
      s3_valid_d = adv3 ? s2_valid_q : s3_valid_q;
      s3_data_d  = s3_data_q;

      if (adv1 && i_valid) begin
         s1_mode_d = i_mode;
         for (int k = 0; k < NUM_CH; k++) begin
            {s1_neg_d[k], s1_m_d[k]} = stage1_lane(i_data[k*DATA_WIDTH +: DATA_WIDTH], i_mode);
         end
      end

      if (adv2 && s1_valid_q) begin
         s2_mode_d = s1_mode_q;
         s2_neg_d  = s1_neg_q;
         for (int k = 0; k < NUM_CH; k++) begin
            s2_sq_d[k] = SW'(s1_m_q[k]) * SW'(s1_m_q[k]);
         end
      end

      if (adv3 && s2_valid_q) begin
         for (int k = 0; k < NUM_CH; k++) begin
            s3_data_d[k*DATA_WIDTH +: DATA_WIDTH] = stage3_lane(s2_sq_q[k], s2_neg_q[k], s2_mode_q);
         end
      end
   end

   // Reset discards every in-flight beat and zeroes the output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_mode_q  <= 1'b0;
         s1_neg_q   <= '0;
         s1_m_q     <= '0;
         s2_valid_q <= 1'b0;
         s2_mode_q  <= 1'b0;
         s2_neg_q   <= '0;
         s2_sq_q    <= '0;
         s3_valid_q <= 1'b0;
         s3_data_q  <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_mode_q  <= s1_mode_d;
         s1_neg_q   <= s1_neg_d;
         s1_m_q     <= s1_m_d;
         s2_valid_q <= s2_valid_d;
         s2_mode_q  <= s2_mode_d;
         s2_neg_q   <= s2_neg_d;
         s2_sq_q    <= s2_sq_d;
         s3_valid_q <= s3_valid_d;
         s3_data_q  <= s3_data_d;
      end
   end

endmodule
